// File: rtl/game_pkg.sv
// Shared types and helpers for the boss-pose round controller.
// Holds FSM encoding, pose width, LFSR constants and BCD arithmetic.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2,
    OVER = 2'd3
  } state_e;

  localparam int POSE_W = 2;

  // x^8+x^6+x^5+x^4+1 as a shift-left tap mask (bits 7,5,4,3)
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // Saturates at 99
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] b
  );
    if (b == 8'h99) return b;
    if (b[3:0] == 4'd9)
      return {b[7:4] + 4'd1, 4'd0};
    return {b[7:4], b[3:0] + 4'd1};
  endfunction

  // Saturates at 00
  function automatic logic [7:0] bcd_dec(
    input logic [7:0] b
  );
    if (b == 8'h00) return b;
    if (b[3:0] == 4'd0)
      return {b[7:4] - 4'd1, 4'd9};
    return {b[7:4], b[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat prescaler: one-clock tick every CLK_PER_BEAT enabled clocks.
// Count restarts from zero whenever enable drops.
module beat_timer #(
  parameter int CLK_PER_BEAT = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic beat_tick
);

  localparam int CW = $clog2(CLK_PER_BEAT + 1);
  localparam logic [CW-1:0] LAST =
    CW'(CLK_PER_BEAT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at LAST, clear when idle
  always_comb begin
    cnt_d = '0;
    if (enable && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign beat_tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: random boss poses, hit scoring, BCD countdown.
// A pose lives for POSE_BEATS beats; time ends the round.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int CLK_PER_BEAT  = 12500000,
  parameter int POSE_BEATS    = 4,
  parameter int BEATS_PER_SEC = 4,
  parameter int GAME_SECONDS  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] player_state,
  output logic [1:0] boss_state,
  output logic       boss_load,
  output logic       round_active,
  output logic       game_over,
  output logic [7:0] score_bcd,
  output logic [7:0] time_bcd,
  output logic [1:0] phase
);

  localparam int PW = $clog2(POSE_BEATS + 1);
  localparam int SW = $clog2(BEATS_PER_SEC + 1);
  localparam logic [7:0] TIME_INIT =
    to_bcd(GAME_SECONDS);
  localparam logic [PW-1:0] POSE_LAST =
    PW'(POSE_BEATS - 1);
  localparam logic [SW-1:0] SEC_LAST =
    SW'(BEATS_PER_SEC - 1);

  state_e            state_q, state_d;
  logic              start_q;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [POSE_W-1:0] boss_q, boss_d;
  logic              boss_load_q, boss_load_d;
  logic [7:0]        score_q, score_d;
  logic [7:0]        time_q, time_d;
  logic [PW-1:0]     pose_q, pose_d;
  logic [SW-1:0]     sec_q, sec_d;
  logic              hit_q, hit_d;

  logic              start_edge;
  logic              beat_tick;
  logic              timer_en;
  logic              pose_end;
  logic              sec_wrap;
  logic [POSE_W-1:0] cand;

  assign start_edge = start && !start_q;
  assign timer_en   = (state_q == SHOW);
  assign pose_end   = beat_tick && (pose_q == POSE_LAST);
  assign sec_wrap   = beat_tick && (sec_q == SEC_LAST);

  beat_timer #(
    .CLK_PER_BEAT(CLK_PER_BEAT)
  ) u_beat (
    .clk      (clk),
    .reset    (reset),
    .enable   (timer_en),
    .beat_tick(beat_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; timeout beats pose expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_edge) state_d = LOAD;
      LOAD: state_d = SHOW;
      SHOW: begin
        if (time_d == 8'h00) state_d = OVER;
        else if (pose_end)   state_d = LOAD;
      end
      OVER: if (start_edge) state_d = LOAD;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    round_active = (state_q == LOAD) ||
                   (state_q == SHOW);
    game_over    = (state_q == OVER);
    phase        = state_q;
  end

  // Datapath: pose pick, counters, score and time
  always_comb begin
    lfsr_d      = lfsr_next(lfsr_q);
    boss_d      = boss_q;
    boss_load_d = (state_q == LOAD);
    score_d     = score_q;
    time_d      = time_q;
    pose_d      = pose_q;
    sec_d       = sec_q;
    hit_d       = hit_q;
    cand        = lfsr_q[1:0];
    if (cand == boss_q) cand = cand + 1'b1;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          score_d = 8'h00;
          time_d  = TIME_INIT;
          sec_d   = '0;
        end
      end
      LOAD: begin
        boss_d = cand;
        pose_d = '0;
        hit_d  = 1'b0;
      end
      SHOW: begin
        if (beat_tick) begin
          pose_d = pose_q + 1'b1;
          sec_d  = sec_wrap ? '0 : sec_q + 1'b1;
          if (sec_wrap) time_d = bcd_dec(time_q);
        end
        if (player_state == boss_q && !hit_q) begin
          hit_d   = 1'b1;
          score_d = bcd_inc(score_q);
        end
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q     <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      boss_q      <= '0;
      boss_load_q <= 1'b0;
      score_q     <= 8'h00;
      time_q      <= TIME_INIT;
      pose_q      <= '0;
      sec_q       <= '0;
      hit_q       <= 1'b0;
    end else begin
      start_q     <= start;
      lfsr_q      <= lfsr_d;
      boss_q      <= boss_d;
      boss_load_q <= boss_load_d;
      score_q     <= score_d;
      time_q      <= time_d;
      pose_q      <= pose_d;
      sec_q       <= sec_d;
      hit_q       <= hit_d;
    end
  end

  assign boss_state = boss_q;
  assign boss_load  = boss_load_q;
  assign score_bcd  = score_q;
  assign time_bcd   = time_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl against a round-level reference model.
// Directed scenarios followed by a randomized pose run.
module tb_game_round_ctrl;

  localparam int CPB = 4;
  localparam int PB  = 2;
  localparam int BPS = 2;
  localparam int GS  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] player_state;
  logic [1:0] boss_state;
  logic       boss_load;
  logic       round_active;
  logic       game_over;
  logic [7:0] score_bcd;
  logic [7:0] time_bcd;
  logic [1:0] phase;

  always #5 clk = ~clk;

  game_round_ctrl #(
    .CLK_PER_BEAT (CPB),
    .POSE_BEATS   (PB),
    .BEATS_PER_SEC(BPS),
    .GAME_SECONDS (GS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .player_state(player_state),
    .boss_state  (boss_state),
    .boss_load   (boss_load),
    .round_active(round_active),
    .game_over   (game_over),
    .score_bcd   (score_bcd),
    .time_bcd    (time_bcd),
    .phase       (phase)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle,1 load,2 show,3 over
  int         m_phase, m_score, m_time;
  int         m_pose_cyc, m_round_cyc;
  int         m_boss, m_load, m_hit, m_prev_start;
  logic [7:0] m_lfsr;

  // 0 mismatch, 1 match, 2 random
  int pl_mode = 0;
  int ld_k[$];
  logic [7:0] ld_t[$];
  int k;
  int n;
  int prev_boss;
  int loads;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic begin_round();
    m_phase     = 1;
    m_score     = 0;
    m_time      = GS;
    m_round_cyc = 0;
  endtask

  task automatic model_clock();
    logic [7:0] nl;
    int edge_s, was_load, p;
    if (reset) begin
      m_phase = 0; m_boss = 0; m_load = 0;
      m_score = 0; m_time = GS; m_hit = 0;
      m_pose_cyc = 0; m_round_cyc = 0;
      m_prev_start = 0; m_lfsr = 8'hA5;
      return;
    end
    edge_s = (start && !m_prev_start) ? 1 : 0;
    m_prev_start = int'(start);
    nl = {m_lfsr[6:0],
          m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    was_load = (m_phase == 1) ? 1 : 0;
    case (m_phase)
      0, 3: if (edge_s != 0) begin_round();
      1: begin
        p = int'(m_lfsr[1:0]);
        if (p == m_boss) p = (p + 1) % 4;
        m_boss = p;
        m_hit = 0;
        m_pose_cyc = 0;
        m_phase = 2;
      end
      default: begin
        if (int'(player_state) == m_boss && m_hit == 0) begin
          m_hit = 1;
          if (m_score < 99) m_score++;
        end
        m_pose_cyc++;
        m_round_cyc++;
        m_time = GS - m_round_cyc / (BPS * CPB);
        if (m_time < 0) m_time = 0;
        if (m_time == 0) m_phase = 3;
        else if (m_pose_cyc == PB * CPB) m_phase = 1;
      end
    endcase
    m_load = was_load;
    m_lfsr = nl;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check("phase", 8'(phase), 8'(m_phase));
    check("boss_state", 8'(boss_state), 8'(m_boss));
    check("boss_load", 8'(boss_load), 8'(m_load));
    check("round_active", 8'(round_active),
          8'((m_phase == 1 || m_phase == 2) ? 1 : 0));
    check("game_over", 8'(game_over),
          8'((m_phase == 3) ? 1 : 0));
    check("score_bcd", score_bcd, bcd(m_score));
    check("time_bcd", time_bcd, bcd(m_time));
    if (boss_load) begin
      ld_k.push_back(k);
      ld_t.push_back(time_bcd);
    end
    case (pl_mode)
      0:       player_state = 2'((m_boss + 1) % 4);
      1:       player_state = 2'(m_boss);
      default: player_state = 2'($urandom_range(0, 3));
    endcase
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    player_state = 2'd0;
    k = 0;
    step();
    reset = 1'b0;
    check("rst_phase", 8'(phase), 8'h00);
    check("rst_score", score_bcd, 8'h00);
    check("rst_time", time_bcd, 8'h03);

    // Idle after reset
    repeat (20) step();
    check("idle_phase", 8'(phase), 8'h00);
    check("idle_loads", 8'(ld_k.size()), 8'h00);
    check("idle_time", time_bcd, 8'h03);

    // Single start pulse, never matching
    ld_k.delete(); ld_t.delete();
    start = 1'b1;
    k = 1;
    step();
    start = 1'b0;
    while (!game_over && k < 60) begin
      k++;
      step();
    end
    check("over_at", 8'(k), 8'd28);
    check("n_poses", 8'(ld_k.size()), 8'd3);
    if (ld_k.size() == 3) begin
      check("first_load", 8'(ld_k[0]), 8'd2);
      check("pose_gap1", 8'(ld_k[1] - ld_k[0]), 8'd9);
      check("pose_gap2", 8'(ld_k[2] - ld_k[1]), 8'd9);
      check("time_p1", ld_t[0], 8'h03);
      check("time_p2", ld_t[1], 8'h02);
      check("time_p3", ld_t[2], 8'h01);
    end
    check("nomatch_score", score_bcd, 8'h00);
    check("nomatch_time", time_bcd, 8'h00);

    // Match for the whole first pose
    ld_k.delete(); ld_t.delete();
    pl_mode = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (ld_k.size() < 2 && n < 30) begin
      n++;
      step();
    end
    pl_mode = 0;
    player_state = 2'((m_boss + 1) % 4);
    check("match_once", score_bcd, 8'h01);
    n = 0;
    while (!game_over && n < 40) begin
      n++;
      step();
    end
    check("match_over", 8'(game_over), 8'h01);
    check("match_final", score_bcd, 8'h01);

    // Start held through a full round
    start = 1'b0;
    step();
    ld_k.delete(); ld_t.delete();
    start = 1'b1;
    repeat (60) step();
    check("held_rounds", 8'(ld_k.size()), 8'd3);
    check("held_over", 8'(phase), 8'h03);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    step();
    check("restart_phase", 8'(phase), 8'h02);
    check("restart_score", score_bcd, 8'h00);
    check("restart_time", time_bcd, 8'h03);
    start = 1'b0;

    // Reset in SHOW with score 01
    pl_mode = 1;
    player_state = 2'(m_boss);
    repeat (3) step();
    check("pre_rst_score", score_bcd, 8'h01);
    pl_mode = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_phase", 8'(phase), 8'h00);
    check("mid_rst_score", score_bcd, 8'h00);
    check("mid_rst_time", time_bcd, 8'h03);
    check("mid_rst_active", 8'(round_active), 8'h00);
    repeat (5) step();
    check("no_restart", 8'(phase), 8'h00);

    // Match only in the cycle time reaches 00
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(m_phase == 2 &&
             m_round_cyc == GS * BPS * CPB - 1) &&
           n < 60) begin
      n++;
      step();
    end
    player_state = 2'(m_boss);
    step();
    check("last_hit_phase", 8'(phase), 8'h03);
    check("last_hit_score", score_bcd, 8'h01);
    check("last_hit_time", time_bcd, 8'h00);

    // Random players across many poses
    pl_mode = 2;
    prev_boss = m_boss;
    loads = 0;
    n = 0;
    while (loads < 1000 && n < 20000) begin
      n++;
      if (game_over) start = ~start;
      step();
      if (boss_load) begin
        loads++;
        n_tests++;
        assert (int'(boss_state) != prev_boss) else begin
          n_fail++;
          $error("FAIL pose_repeat observed=%0d expected!=%0d",
                 boss_state, prev_boss);
        end
        prev_boss = int'(boss_state);
      end
    end
    n_tests++;
    assert (loads >= 1000) else begin
      n_fail++;
      $error("FAIL load_count observed=%0d expected=1000",
             loads);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
